// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - LCD power-up / frame-loop sequencer; optional LCD_HW_RESET_EN adds the hardware reset phase
module lcd_sequencer #(
  parameter int RST_LOW_CYC     = 10000,
  parameter int RST_WAIT_CYC    = 1200000,
  parameter int SLPOUT_WAIT_CYC = 12000000,
  parameter int TIMEOUT_CYC     = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_comm_array_sent,
  input  logic        i_pix_done,
  output logic        o_send_comm_ena,
  output logic        o_command,
  output logic        o_lcd_rst_n,
  output logic        o_pix_ena,
  output logic        o_ready,
  output logic        o_err,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_HWRST, S_HWWAIT, S_INIT, S_SLPWAIT, S_LOOP_CMD, S_PIXELS, S_HALT, S_ERROR
  } state_t;

  // Wait counters are loaded with N-1 so a state with count N lasts exactly N cycles.
  localparam logic [23:0] RST_LOW_LD  = 24'(RST_LOW_CYC - 1);
  localparam logic [23:0] RST_WAIT_LD = 24'(RST_WAIT_CYC - 1);
  localparam logic [23:0] SLP_LD      = 24'(SLPOUT_WAIT_CYC - 1);
  localparam logic [23:0] TOUT_LAST   = 24'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [23:0] wait_q, wait_ld, tout_q;
  logic        stop_q, stop_arm, stop_now;
  logic        wait_done, tout_hit, entering, frame_inc;
  logic        send_d, cmd_d, rstn_d, pix_d, ready_d, err_d;

  // Next-state and next-output decode; a done pulse in the last allowed cycle beats the timeout.
  always_comb begin
    state_d   = state_q;
    stop_arm  = i_stop && (state_q == S_LOOP_CMD || state_q == S_PIXELS);
    stop_now  = stop_q || stop_arm;
    wait_done = (wait_q == 24'd0);
    tout_hit  = (tout_q == TOUT_LAST);
    frame_inc = (state_q == S_PIXELS) && i_pix_done;
    case (state_q)
      S_IDLE: if (i_start) begin
`ifdef LCD_HW_RESET_EN
        state_d = S_HWRST;
`else
        state_d = S_INIT;
`endif
      end
      S_HWRST:    if (wait_done) state_d = S_HWWAIT;
      S_HWWAIT:   if (wait_done) state_d = S_INIT;
      S_INIT:     if (i_comm_array_sent) state_d = S_SLPWAIT;
                  else if (tout_hit) state_d = S_ERROR;
      S_SLPWAIT:  if (wait_done) state_d = S_LOOP_CMD;
      S_LOOP_CMD: if (i_comm_array_sent) state_d = S_PIXELS;
                  else if (tout_hit) state_d = S_ERROR;
      S_PIXELS:   if (i_pix_done) state_d = stop_now ? S_HALT : S_LOOP_CMD;
                  else if (tout_hit) state_d = S_ERROR;
      S_HALT:     if (i_start) state_d = S_LOOP_CMD;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_IDLE;
    endcase

    entering = (state_d != state_q);
    case (state_d)
      S_HWRST:  wait_ld = RST_LOW_LD;
      S_HWWAIT: wait_ld = RST_WAIT_LD;
      default:  wait_ld = SLP_LD;
    endcase

    send_d  = entering && (state_d == S_INIT || state_d == S_LOOP_CMD);
    cmd_d   = o_command;
    if (state_d == S_LOOP_CMD) cmd_d = 1'b1;
    else if (state_d == S_INIT) cmd_d = 1'b0;
    pix_d   = (state_d == S_PIXELS);
    ready_d = (state_d == S_LOOP_CMD || state_d == S_PIXELS || state_d == S_HALT);
    err_d   = (state_d == S_ERROR);
`ifdef LCD_HW_RESET_EN
    rstn_d  = (state_d != S_HWRST);
`else
    rstn_d  = 1'b1;
`endif
  end

  // State, counters, stop latch, frame counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wait_q          <= '0;
      tout_q          <= '0;
      stop_q          <= 1'b0;
      o_send_comm_ena <= 1'b0;
      o_command       <= 1'b0;
      o_lcd_rst_n     <= 1'b1;
      o_pix_ena       <= 1'b0;
      o_ready         <= 1'b0;
      o_err           <= 1'b0;
      o_frame_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (entering) wait_q <= wait_ld;
      else if (!wait_done) wait_q <= wait_q - 24'd1;
      if (entering) tout_q <= '0;
      else if (!tout_hit) tout_q <= tout_q + 24'd1;
      if (state_q == S_HALT && i_start) stop_q <= 1'b0;
      else if (stop_arm) stop_q <= 1'b1;
      if (frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
      o_send_comm_ena <= send_d;
      o_command       <= cmd_d;
      o_lcd_rst_n     <= rstn_d;
      o_pix_ena       <= pix_d;
      o_ready         <= ready_d;
      o_err           <= err_d;
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - directed/randomized self-checking bench for lcd_sequencer
module tb_lcd_sequencer;
  localparam int RLOW = 4, RWAIT = 6, SLP = 10, TOUT = 50;
`ifdef LCD_HW_RESET_EN
  localparam int EXP_LOW = RLOW;
  localparam int EXP_TO_INIT = RLOW + RWAIT;
`else
  localparam int EXP_LOW = 0;
  localparam int EXP_TO_INIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, i_start, i_stop, i_comm_array_sent, i_pix_done;
  logic        o_send_comm_ena, o_command, o_lcd_rst_n, o_pix_ena, o_ready, o_err;
  logic [15:0] o_frame_cnt;

  int n_cmp = 0, n_err = 0;
  int exp_frames = 0;

  lcd_sequencer #(.RST_LOW_CYC(RLOW), .RST_WAIT_CYC(RWAIT), .SLPOUT_WAIT_CYC(SLP), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_comm_array_sent(i_comm_array_sent), .i_pix_done(i_pix_done),
    .o_send_comm_ena(o_send_comm_ena), .o_command(o_command), .o_lcd_rst_n(o_lcd_rst_n),
    .o_pix_ena(o_pix_ena), .o_ready(o_ready), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_send"}, o_send_comm_ena, 0);
    chk({tag, "_cmd"}, o_command, 0);
    chk({tag, "_rstn"}, o_lcd_rst_n, 1);
    chk({tag, "_pix"}, o_pix_ena, 0);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_frames"}, o_frame_cnt, 0);
  endtask

  // Starts in LOOP_CMD; runs one command array plus one frame with random latencies.
  task automatic run_frame(input string tag, input bit stop_with_done, input bit stop_early);
    int d1, d2;
    d1 = int'($urandom_range(0, 20));
    d2 = int'($urandom_range(0, 20));
    i_stop = stop_early;
    repeat (d1) begin
      tick();
      i_stop = 1'b0;
    end
    i_comm_array_sent = 1'b1;
    tick();
    i_comm_array_sent = 1'b0;
    i_stop = 1'b0;
    chk({tag, "_pix_on"}, o_pix_ena, 1);
    repeat (d2) begin
      i_comm_array_sent = 1'($urandom_range(0, 1));
      tick();
    end
    i_comm_array_sent = 1'b0;
    i_pix_done = 1'b1;
    i_stop = stop_with_done;
    tick();
    i_pix_done = 1'b0;
    i_stop = 1'b0;
    exp_frames = (exp_frames + 1) % 65536;
    chk({tag, "_frames"}, o_frame_cnt, exp_frames);
    chk({tag, "_pix_off"}, o_pix_ena, 0);
    chk({tag, "_ready"}, o_ready, 1);
    if (stop_with_done || stop_early) begin
      chk({tag, "_halt_send"}, o_send_comm_ena, 0);
    end else begin
      chk({tag, "_loop_send"}, o_send_comm_ena, 1);
      chk({tag, "_loop_cmd"}, o_command, 1);
    end
  endtask

  // Waits for a command-array pulse; returns observed latency and count of low reset-pin cycles.
  task automatic wait_pulse(output int idx, output int low, output int rdy_low);
    idx = 0; low = 0; rdy_low = 0;
    while (!o_send_comm_ena && idx < 200) begin
      if (!o_lcd_rst_n) low++;
      if (!o_ready) rdy_low++;
      i_pix_done = 1'($urandom_range(0, 1));
      i_stop = 1'($urandom_range(0, 1));
      tick();
      idx++;
    end
    i_pix_done = 1'b0;
    i_stop = 1'b0;
  endtask

  initial begin
    int idx, low, rdy_low, d;
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_comm_array_sent = 1'b0; i_pix_done = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Idle ignores done pulses and stop.
    repeat (5) begin
      i_pix_done = 1'($urandom_range(0, 1));
      i_comm_array_sent = 1'($urandom_range(0, 1));
      i_stop = 1'($urandom_range(0, 1));
      tick();
      chk("idle_send", o_send_comm_ena, 0);
      chk("idle_frames", o_frame_cnt, 0);
    end
    i_pix_done = 1'b0; i_comm_array_sent = 1'b0; i_stop = 1'b0;

    // Bring-up.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_pulse(idx, low, rdy_low);
    chk("bringup_latency", idx, EXP_TO_INIT);
    chk("bringup_rst_low", low, EXP_LOW);
    chk("bringup_cmd", o_command, 0);
    chk("bringup_rstn", o_lcd_rst_n, 1);
    chk("bringup_ready", o_ready, 0);
    d = int'($urandom_range(0, 20));
    repeat (d) begin
      i_pix_done = 1'($urandom_range(0, 1));
      tick();
    end
    i_pix_done = 1'b0;
    i_comm_array_sent = 1'b1;
    tick();
    i_comm_array_sent = 1'b0;
    wait_pulse(idx, low, rdy_low);
    chk("slpout_latency", idx, SLP);
    chk("slpout_ready_low", rdy_low, SLP);
    chk("slpout_ready", o_ready, 1);
    chk("slpout_cmd", o_command, 1);
    chk("slpout_frames", o_frame_cnt, 0);
    tick();
    chk("pulse_width", o_send_comm_ena, 0);

    // Three frames, then counter wrap.
    for (int f = 0; f < 3; f++) run_frame("frame", 1'b0, 1'b0);
    chk("three_frames", o_frame_cnt, 3);
    force dut.o_frame_cnt = 16'hFFFF;
    #1;
    release dut.o_frame_cnt;
    exp_frames = 16'hFFFF;
    run_frame("wrap", 1'b0, 1'b0);
    chk("wrap_zero", o_frame_cnt, 0);

    // Stop with the frame done, idle in HALT, resume without init or reset pin.
    run_frame("stop_same", 1'b1, 1'b0);
    d = int'($urandom_range(1, 8));
    repeat (d) begin
      i_pix_done = 1'($urandom_range(0, 1));
      i_comm_array_sent = 1'($urandom_range(0, 1));
      tick();
      chk("halt_frames", o_frame_cnt, exp_frames);
      chk("halt_send", o_send_comm_ena, 0);
      chk("halt_ready", o_ready, 1);
    end
    i_pix_done = 1'b0; i_comm_array_sent = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("resume_send", o_send_comm_ena, 1);
    chk("resume_cmd", o_command, 1);
    chk("resume_rstn", o_lcd_rst_n, 1);
    run_frame("stop_early", 1'b0, 1'b1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("resume2_send", o_send_comm_ena, 1);
    chk("resume2_cmd", o_command, 1);

    // Done pulses landing on the last allowed cycle do not time out.
    repeat (TOUT - 1) tick();
    chk("edge_cmd_err", o_err, 0);
    i_comm_array_sent = 1'b1;
    tick();
    i_comm_array_sent = 1'b0;
    chk("edge_cmd_pix", o_pix_ena, 1);
    chk("edge_cmd_err2", o_err, 0);
    repeat (TOUT - 1) tick();
    i_pix_done = 1'b1;
    tick();
    i_pix_done = 1'b0;
    exp_frames = (exp_frames + 1) % 65536;
    chk("edge_pix_frames", o_frame_cnt, exp_frames);
    chk("edge_pix_send", o_send_comm_ena, 1);
    chk("edge_pix_err", o_err, 0);

    // Reset while streaming pixels.
    i_comm_array_sent = 1'b1;
    tick();
    i_comm_array_sent = 1'b0;
    repeat (int'($urandom_range(0, 10))) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_frames = 0;
    chk_reset_vals("midrst");
    repeat (3) begin
      tick();
      chk("midrst_nopulse", o_send_comm_ena, 0);
    end

    // Init array never completes.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_pulse(idx, low, rdy_low);
    chk("tout_latency", idx, EXP_TO_INIT);
    repeat (TOUT - 1) tick();
    chk("tout_before", o_err, 0);
    tick();
    chk("tout_err", o_err, 1);
    chk("tout_ready", o_ready, 0);
    chk("tout_pix", o_pix_ena, 0);
    repeat (5) begin
      i_start = 1'($urandom_range(0, 1));
      i_comm_array_sent = 1'($urandom_range(0, 1));
      i_pix_done = 1'($urandom_range(0, 1));
      tick();
      chk("err_held", o_err, 1);
      chk("err_send", o_send_comm_ena, 0);
      chk("err_frames", o_frame_cnt, 0);
    end
    i_start = 1'b0; i_comm_array_sent = 1'b0; i_pix_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("err_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter RST_LOW_CYC, default 10000: cycles o_lcd_rst_n is held low; range 1..2^24-1.
REQ-002 Parameter RST_WAIT_CYC, default 1200000: cycles waited after reset release before the init array; range 1..2^24-1.
REQ-003 Parameter SLPOUT_WAIT_CYC, default 12000000: cycles waited after the init array completes; range 1..2^24-1.
REQ-004 Parameter TIMEOUT_CYC, default 1000000: maximum cycles allowed for any command array or pixel frame; range 1..2^24-1.
REQ-005 clk  input  1  sole clock; all logic is on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_start  input  1  start request, sampled only in IDLE and HALT.
REQ-008 i_stop  input  1  stop request; latched while in LOOP_CMD or PIXELS.
REQ-009 i_comm_array_sent  input  1  one-cycle done pulse from the command-array sender.
REQ-010 i_pix_done  input  1  one-cycle pulse from the pixel streamer when a frame is complete.
REQ-011 o_send_comm_ena  output  1  one-cycle pulse that starts the command-array sender.
REQ-012 o_command  output  1  array select: 0 = init array, 1 = loop array.
REQ-013 o_lcd_rst_n  output  1  LCD hardware reset pin, active-low.
REQ-014 o_pix_ena  output  1  level enable for the pixel streamer.
REQ-015 o_ready  output  1  high once the panel is initialised.
REQ-016 o_err  output  1  sticky timeout flag.
REQ-017 o_frame_cnt  output  16  count of completed frames.

Function
REQ-018 States: IDLE, HWRST, HWWAIT, INIT, SLPWAIT, LOOP_CMD, PIXELS, HALT, ERROR. All outputs are registered.
REQ-019 IDLE: on i_start=1, go to HWRST. HWRST: hold o_lcd_rst_n=0 for exactly RST_LOW_CYC cycles, then go to HWWAIT.
REQ-020 HWWAIT: stay exactly RST_WAIT_CYC cycles, then go to INIT. SLPWAIT: stay exactly SLPOUT_WAIT_CYC cycles, set o_ready=1, then go to LOOP_CMD.
REQ-021 INIT (o_command=0) and LOOP_CMD (o_command=1): o_send_comm_ena is high only in the first cycle of the state.
REQ-022 On i_comm_array_sent: INIT goes to SLPWAIT; LOOP_CMD goes to PIXELS.
REQ-023 PIXELS: o_pix_ena=1. On i_pix_done, o_frame_cnt increments (0xFFFF wraps to 0x0000). The FSM then goes to HALT if a stop is latched, otherwise to LOOP_CMD.
REQ-024 HALT: o_ready=1. On i_start=1, clear the stop latch and go to LOOP_CMD; the init array is skipped.
REQ-025 Timeout: one 24-bit counter is cleared on entry to INIT, LOOP_CMD and PIXELS. If it reaches TIMEOUT_CYC without the expected done pulse, go to ERROR.
REQ-026 ERROR: o_err=1, o_ready=0, o_pix_ena=0, o_send_comm_ena=0. Only rst exits ERROR.
REQ-027 i_comm_array_sent and i_pix_done are ignored in every state that does not wait for them; o_frame_cnt does not change.
REQ-028 A done pulse that arrives in the same cycle the timeout count is reached wins; no error is raised.
REQ-029 i_stop and i_pix_done in the same cycle in PIXELS: go to HALT and increment o_frame_cnt.
REQ-030 i_stop has no effect outside LOOP_CMD and PIXELS.
REQ-031 The wait counter reloads on every state entry. A state with a wait count of N occupies exactly N cycles.

Reset
REQ-032 rst=1 at a clock edge: state=IDLE, o_send_comm_ena=0, o_command=0, o_lcd_rst_n=1, o_pix_ena=0, o_ready=0, o_err=0, o_frame_cnt=0, stop latch and all counters cleared.
REQ-033 Reset mid-operation, in any state, takes effect at that same edge; no pending pulse is emitted afterwards.

Configuration
REQ-034 Macro LCD_HW_RESET_EN defined: the full IDLE -> HWRST -> HWWAIT -> INIT path applies.
REQ-035 LCD_HW_RESET_EN undefined: HWRST and HWWAIT are removed, IDLE goes directly to INIT on i_start, o_lcd_rst_n is constant 1, and RST_LOW_CYC and RST_WAIT_CYC are unused.

Verification
Bench parameters: RST_LOW_CYC=4, RST_WAIT_CYC=6, SLPOUT_WAIT_CYC=10, TIMEOUT_CYC=50.
REQ-036 Bring-up with macro defined: i_start pulse in IDLE -> o_lcd_rst_n low for 4 cycles, then 6 wait cycles, then an o_send_comm_ena pulse with o_command=0. Done pulse -> 10 cycles -> o_ready=1 and a pulse with o_command=1.
REQ-037 Frame loop: 3 i_pix_done pulses -> o_frame_cnt=3 and an o_command=1 pulse after each frame. Preload 0xFFFF plus one frame -> o_frame_cnt=0x0000.
REQ-038 Stop/resume: i_stop in the same cycle as i_pix_done -> HALT with o_pix_ena=0 and o_ready=1. i_start -> LOOP_CMD pulse with no init and no reset pulse.
REQ-039 Timeout: no i_comm_array_sent for 50 cycles in INIT -> o_err=1 and held. Done pulse exactly at cycle 50 -> no error.
REQ-040 Reset mid-operation: rst in PIXELS -> all outputs at reset values at the next edge.
REQ-041 Macro undefined: i_start -> o_send_comm_ena pulse (o_command=0) on the cycle after IDLE exits, with o_lcd_rst_n constant 1.
